axi_line_fetch: RTL and testbench

AXI_LINE_FETCH -- requirements
Module: axi_line_fetch

---
 rtl/axi_line_fetch.sv | 175 +++++++++++++++++
 tb/tb_axi_line_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_fetch.sv
// axi_line_fetch: fetches one cache line over an AXI4 read channel (single INCR burst)
// and hands it to the cache as a flat line buffer with a one-cycle gnt pulse.
//
// Parameters:
//   OFFSET_LEN  byte-offset width of a line; line holds 2^(OFFSET_LEN-2) 32-bit words
//   AXI_ID      fixed ARID; R beats carrying any other RID are ignored
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req, addr              refill request (held until gnt) and refill address
//   gnt                    one-cycle pulse: line buffer complete and valid
//   line                   line buffer, word k = bytes 4k..4k+3 of the line
//   arid..arburst, arvalid AXI AR channel outputs (all zero while arvalid=0)
//   arready                AXI AR channel ready
//   rid, rdata, rresp,     AXI R channel inputs
//   rlast, rvalid
//   rready                 AXI R channel ready (high only while collecting beats)
//   err                    only with AXI_LINE_FETCH_ERR_EN: some accepted beat of the last
//                          burst returned rresp != OKAY; valid from gnt to the next request
//
// Build option: define AXI_LINE_FETCH_ERR_EN to add the err output.

module axi_line_fetch #(
    parameter int         OFFSET_LEN = 5,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req,
    input  logic [31:0]                         addr,
    output logic                                gnt,
    output logic [32*(2**(OFFSET_LEN-2))-1:0]   line,
    output logic [3:0]                          arid,
    output logic [31:0]                         araddr,
    output logic [7:0]                          arlen,
    output logic [2:0]                          arsize,
    output logic [1:0]                          arburst,
    output logic                                arvalid,
    input  logic                                arready,
    input  logic [3:0]                          rid,
    input  logic [31:0]                         rdata,
    input  logic [1:0]                          rresp,
    input  logic                                rlast,
    input  logic                                rvalid,
    output logic                                rready
`ifdef AXI_LINE_FETCH_ERR_EN
    ,
    output logic                                err
`endif
);

    localparam int WORDS = 2 ** (OFFSET_LEN - 2);
    localparam int CNT_W = (OFFSET_LEN > 3) ? OFFSET_LEN - 2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        words_q [WORDS];

    logic accept;
    logic beat;

    assign accept = (state_q == StIdle) && req;
    // Foreign-ID beats are neither stored nor counted, and cannot end the burst.
    assign beat   = (state_q == StData) && rvalid && (rid == AXI_ID);

    // Line offset bits of the request address are don't-care.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[OFFSET_LEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < WORDS; k++) begin
                words_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= {addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                cnt_q  <= '0;
            end
            if (beat) begin
                words_q[cnt_q] <= rdata;
                // Saturate: any surplus beats keep overwriting the last word.
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        rready  = 1'b0;
        gnt     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                arvalid = 1'b1;
                arid    = AXI_ID;
                araddr  = addr_q;
                arlen   = 8'(WORDS - 1);
                arsize  = 3'b010;
                arburst = 2'b01;
                if (arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                rready = 1'b1;
                if (beat && rlast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        line = '0;
        for (int k = 0; k < WORDS; k++) begin
            line[32*k +: 32] = words_q[k];
        end
    end

`ifdef AXI_LINE_FETCH_ERR_EN
    logic err_acc_q;
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                err_acc_q <= 1'b0;
                err_q     <= 1'b0;
            end
            if (beat && (rresp != 2'b00)) begin
                err_acc_q <= 1'b1;
            end
            // Publish the burst's error status on the same edge that enters DONE.
            if (beat && rlast) begin
                err_q <= err_acc_q | (rresp != 2'b00);
            end
        end
    end

    assign err = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
`endif

endmodule

// File: tb/tb_axi_line_fetch.sv
// Directed testbench for axi_line_fetch (default OFFSET_LEN=5, AXI_ID=0).
// Cycle numbering: the edge that samples req in IDLE is cycle 1, so gnt of a zero-wait
// 8-beat fetch is observed after the 10th edge (the 11th cycle counting the req cycle).
module tb_axi_line_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [31:0]  addr;
    logic         gnt;
    logic [255:0] line;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
`ifdef AXI_LINE_FETCH_ERR_EN
    logic         err;
`endif

    int errors = 0;
    int checks = 0;

    axi_line_fetch dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .addr    (addr),
        .gnt     (gnt),
        .line    (line),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
`ifdef AXI_LINE_FETCH_ERR_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [49:0] AR_IDLE = 50'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base, input int nbeats);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < nbeats; k++) begin
            v[32*((k > 7) ? 7 : k) +: 32] = base + 32'(k);
        end
        return v;
    endfunction

    function automatic logic [49:0] mk_ar(input logic [31:0] a);
        return {1'b1, 4'd0, a, 8'd7, 3'b010, 2'b01};
    endfunction

    // Drives one complete fetch from IDLE. Stimulus only; callers do the comparisons.
    task automatic run_fetch(input logic [31:0] a, input int ar_wait, input int gap,
                             input int foreign_k, input int err_k, input int nbeats,
                             input logic [31:0] base, output int gcyc,
                             output logic [49:0] ar_snap, output bit ar_ok,
                             output bit timeout);
        int cyc;
        cyc = 0; gcyc = -1; ar_ok = 1'b1; timeout = 1'b0;
        addr = a; req = 1'b1; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        tick(); cyc++;
        // Drop req and scramble addr: neither may disturb the started fetch.
        req = 1'b0; addr = 32'hFFFF_FFFF;
        ar_snap = {arvalid, arid, araddr, arlen, arsize, arburst};
        for (int w = 0; w < ar_wait; w++) begin
            if ({arvalid, arid, araddr, arlen, arsize, arburst} !== ar_snap) ar_ok = 1'b0;
            tick(); cyc++;
        end
        if ({arvalid, arid, araddr, arlen, arsize, arburst} !== ar_snap) ar_ok = 1'b0;
        arready = 1'b1;
        tick(); cyc++;
        arready = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    rvalid = 1'b0;
                    tick(); cyc++;
                end
            end
            if (k == foreign_k) begin
                rvalid = 1'b1; rid = 4'd3; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rresp = 2'b10;
                tick(); cyc++;
            end
            rvalid = 1'b1; rid = 4'd0; rdata = base + 32'(k); rlast = (k == nbeats - 1);
            rresp = (k == err_k) ? 2'b10 : 2'b00;
            tick(); cyc++;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        for (int t = 0; t < 8; t++) begin
            if (gnt === 1'b1) begin
                gcyc = cyc;
                break;
            end
            tick(); cyc++;
        end
        if (gcyc < 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; addr = '0; arready = 1'b0; rid = '0; rdata = '0;
        rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        #12;
        checks++;
        if ({gnt, rready, arvalid, arid, araddr, arlen, arsize, arburst} !== 53'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {gnt, rready, arvalid, arid, araddr, arlen, arsize, arburst});
        end
        checks++;
        if (line !== 256'd0) begin
            errors++; $display("FAIL reset_line: got %h expected 0", line);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt, arvalid} !== 2'b00) begin
            errors++; $display("FAIL idle_no_req: got %b expected 00", {gnt, arvalid});
        end
    endtask

    task automatic test_basic();
        int gc; logic [49:0] snap; bit ok; bit to;
        run_fetch(32'hBFC0_0014, 0, 0, -1, -1, 8, 32'h100, gc, snap, ok, to);
        checks++;
        if (snap !== mk_ar(32'hBFC0_0000)) begin
            errors++; $display("FAIL basic_ar: got %h expected %h", snap, mk_ar(32'hBFC0_0000));
        end
        checks++;
        if (to || gc != 10) begin
            errors++; $display("FAIL basic_latency: got %0d expected 10", gc);
        end
        checks++;
        if (line !== mk_line(32'h100, 8)) begin
            errors++; $display("FAIL basic_line: got %h expected %h", line, mk_line(32'h100, 8));
        end
        tick();
        checks++;
        if ({gnt, rready, arvalid, arid, araddr, arlen, arsize, arburst} !== 53'd0) begin
            errors++; $display("FAIL basic_gnt_one_cycle: got %h expected 0",
                               {gnt, rready, arvalid, arid, araddr, arlen, arsize, arburst});
        end
    endtask

    task automatic test_ar_wait();
        int gc; logic [49:0] snap; bit ok; bit to;
        run_fetch(32'h8000_1234, 5, 0, -1, -1, 8, 32'h200, gc, snap, ok, to);
        checks++;
        if (!ok || snap !== mk_ar(32'h8000_1220)) begin
            errors++; $display("FAIL arwait_stable: got ok=%0d ar=%h expected ok=1 ar=%h",
                               ok, snap, mk_ar(32'h8000_1220));
        end
        checks++;
        if (to || gc != 15) begin
            errors++; $display("FAIL arwait_latency: got %0d expected 15", gc);
        end
        checks++;
        if (line !== mk_line(32'h200, 8)) begin
            errors++; $display("FAIL arwait_line: got %h expected %h", line, mk_line(32'h200, 8));
        end
        tick();
    endtask

    task automatic test_gaps_foreign();
        int gc; logic [49:0] snap; bit ok; bit to;
        run_fetch(32'h0000_0080, 0, 2, 3, -1, 8, 32'h300, gc, snap, ok, to);
        checks++;
        if (to || gc != 25) begin
            errors++; $display("FAIL gaps_latency: got %0d expected 25", gc);
        end
        checks++;
        if (line !== mk_line(32'h300, 8)) begin
            errors++; $display("FAIL gaps_line: got %h expected %h", line, mk_line(32'h300, 8));
        end
        tick();
    endtask

    task automatic test_saturate();
        int gc; logic [49:0] snap; bit ok; bit to;
        run_fetch(32'h0000_00A0, 0, 0, -1, -1, 10, 32'h400, gc, snap, ok, to);
        checks++;
        if (to || gc != 12) begin
            errors++; $display("FAIL sat_latency: got %0d expected 12", gc);
        end
        checks++;
        if (line !== mk_line(32'h400, 10)) begin
            errors++; $display("FAIL sat_line: got %h expected %h", line, mk_line(32'h400, 10));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int gc; logic [49:0] snap; bit ok; bit to;
        run_fetch(32'h0000_0040, 0, 0, -1, -1, 8, 32'h500, gc, snap, ok, to);
        checks++;
        if (to || gc != 10) begin
            errors++; $display("FAIL b2b_first_latency: got %0d expected 10", gc);
        end
        // Request the next line while still in DONE.
        req = 1'b1; addr = 32'h1000_001C;
        tick();
        checks++;
        if ({gnt, arvalid} !== 2'b00 || line !== mk_line(32'h500, 8)) begin
            errors++; $display("FAIL b2b_idle_hold: got gnt/arvalid=%b line=%h expected 00 line=%h",
                               {gnt, arvalid}, line, mk_line(32'h500, 8));
        end
        tick();
        req = 1'b0;
        checks++;
        if ({arvalid, arid, araddr, arlen, arsize, arburst} !== mk_ar(32'h1000_0000)) begin
            errors++; $display("FAIL b2b_accept: got %h expected %h",
                               {arvalid, arid, araddr, arlen, arsize, arburst},
                               mk_ar(32'h1000_0000));
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if ({rready, arvalid, araddr} !== {1'b1, 1'b0, 32'd0}) begin
            errors++; $display("FAIL b2b_data_state: got %h expected %h",
                               {rready, arvalid, araddr}, {1'b1, 1'b0, 32'd0});
        end
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = 32'h600 + 32'(k); rlast = (k == 7);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        checks++;
        if (gnt !== 1'b1 || line !== mk_line(32'h600, 8)) begin
            errors++; $display("FAIL b2b_second: got gnt=%b line=%h expected 1 line=%h",
                               gnt, line, mk_line(32'h600, 8));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int gc; logic [49:0] snap; bit ok; bit to;
        req = 1'b1; addr = 32'h0000_0100;
        tick();
        req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = 32'h7700 + 32'(k); rlast = 1'b0;
            tick();
        end
        rdata = 32'h7704;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, rready, arvalid, arid, araddr, arlen, arsize, arburst} !== 53'd0
            || line !== 256'd0) begin
            errors++; $display("FAIL midreset_clear: got ctl=%h line=%h expected 0",
                               {gnt, rready, arvalid, arid, araddr, arlen, arsize, arburst},
                               line);
        end
        rvalid = 1'b0;
        tick();
        rst = 1'b0;
        run_fetch(32'h0000_0120, 0, 0, -1, -1, 8, 32'h700, gc, snap, ok, to);
        checks++;
        if (to || gc != 10 || line !== mk_line(32'h700, 8)) begin
            errors++; $display("FAIL midreset_refetch: got cyc=%0d line=%h expected 10 line=%h",
                               gc, line, mk_line(32'h700, 8));
        end
        tick();
    endtask

`ifdef AXI_LINE_FETCH_ERR_EN
    task automatic test_err();
        int gc; logic [49:0] snap; bit ok; bit to;
        run_fetch(32'h0000_0200, 0, 0, -1, 2, 8, 32'h800, gc, snap, ok, to);
        checks++;
        if (to || err !== 1'b1) begin
            errors++; $display("FAIL err_set: got %b expected 1", err);
        end
        tick();
        // Foreign beat carries SLVERR and must not count.
        run_fetch(32'h0000_0220, 0, 0, 1, -1, 8, 32'h900, gc, snap, ok, to);
        checks++;
        if (to || err !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b expected 0", err);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ar_wait();
        test_gaps_foreign();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_LINE_FETCH_ERR_EN
        test_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
